// File: rtl/pe_feeder_pkg.sv
// Shared types and helpers for the PE-array feeder: FSM state encoding,
// location-counter width and the per-lane skew latency.
package pe_feeder_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StWload,
    StWdone
  } feeder_state_e;

  localparam int unsigned DefN = 5;

  function automatic int unsigned loc_width(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  localparam int unsigned LOC_W = loc_width(DefN);

  // Cycles from row accept to the lane's output, lane 0 being one register.
  function automatic int unsigned lane_latency(input int unsigned i, input int unsigned stagger);
    return 1 + i * stagger;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying a data word plus valid bit, with
// synchronous clear. Output data is forced to zero when its stage is invalid.
module skew_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             pending_o
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;

  always_comb begin
    data_d[0]  = valid_i ? data_i : '0;
    valid_d[0] = valid_i;
    for (int s = 1; s < DEPTH; s++) begin
      data_d[s]  = data_q[s-1];
      valid_d[s] = valid_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int s = 0; s < DEPTH; s++) data_q[s] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign data_o  = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;

  // Valid data still upstream of the output stage.
  if (DEPTH > 1) begin : g_pend
    assign pending_o = |valid_q[DEPTH-2:0];
  end else begin : g_nopend
    assign pending_o = 1'b0;
  end

endmodule

// File: rtl/pe_array_feeder.sv
// Feeds PE_array: serialises N*N weights onto the preload port and skews row
// pairs into diagonal wavefronts. Optional row counter via FEEDER_ROW_CNT_EN.
module pe_array_feeder
  import pe_feeder_pkg::*;
#(
  parameter int unsigned PORT_WIDTH = 8,
  parameter int unsigned N          = 5,
  parameter int unsigned STAGGER    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wload_start,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [PORT_WIDTH-1:0]     w_data,
  input  logic                      row_valid,
  output logic                      row_ready,
  input  logic [N*PORT_WIDTH-1:0]   row_a,
  input  logic [N*PORT_WIDTH-1:0]   row_b,
  output logic                      WorI,
  output logic [PORT_WIDTH-1:0]     weight_in,
  output logic [loc_width(N)-1:0]   weight_location,
  output logic [N*PORT_WIDTH-1:0]   a_out,
  output logic [N*PORT_WIDTH-1:0]   b_out,
  output logic                      busy,
  output logic                      wload_done
`ifdef FEEDER_ROW_CNT_EN
  ,
  output logic [15:0]               row_cnt
`endif
);

  localparam int unsigned     LocW    = loc_width(N);
  localparam logic [LocW-1:0] LastLoc = LocW'(N * N - 1);

  feeder_state_e         state_q, state_d;
  logic                  wori_q, wori_d;
  logic                  done_q, done_d;
  logic [PORT_WIDTH-1:0] win_q, win_d;
  logic [LocW-1:0]       wloc_q, wloc_d;
  logic [LocW-1:0]       cnt_q, cnt_d;

  logic [N-1:0] a_vld, a_pend, b_vld, b_pend;
  logic         lines_busy, lines_drained, w_xfer, row_acc, wload_entry;

  assign lines_busy    = |{a_vld, a_pend, b_vld, b_pend};
  // Lane N-1 is the longest line, so once nothing is upstream of any output
  // stage the last valid word is leaving on this edge.
  assign lines_drained = ~|{a_pend, b_pend};

  assign w_ready   = rst_n && (state_q == StWload);
  assign row_ready = rst_n && (state_q == StIdle) && !wload_start;
  assign w_xfer    = w_valid && w_ready;
  assign row_acc   = row_valid && row_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    wloc_d  = wloc_q;
    unique case (state_q)
      StIdle: begin
        if (wload_start) state_d = lines_busy ? StDrain : StWload;
      end
      StDrain: begin
        if (lines_drained) state_d = StWload;
      end
      StWload: begin
        if (w_xfer) begin
          win_d  = w_data;
          wloc_d = cnt_q;
          cnt_d  = cnt_q + LocW'(1);
          if (cnt_q == LastLoc) state_d = StWdone;
        end
      end
      StWdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    wload_entry = (state_q != StWload) && (state_d == StWload);
    if (wload_entry) cnt_d = '0;
    // Hold WorI one cycle past WDONE so the final registered write is framed.
    wori_d = (state_d == StWload) || (state_d == StWdone) || (state_q == StWdone);
    done_d = (state_d == StWdone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      win_q   <= '0;
      wloc_q  <= '0;
      wori_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      wloc_q  <= wloc_d;
      wori_q  <= wori_d;
      done_q  <= done_d;
    end
  end

  assign WorI            = wori_q;
  assign weight_in       = win_q;
  assign weight_location = wloc_q;
  assign wload_done      = done_q;
  assign busy            = (state_q != StIdle) || lines_busy;

`ifdef FEEDER_ROW_CNT_EN
  logic [15:0] rcnt_q, rcnt_d;

  always_comb begin
    rcnt_d = rcnt_q;
    if (wload_entry) rcnt_d = '0;
    else if (row_acc && (rcnt_q != 16'hFFFF)) rcnt_d = rcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rcnt_q <= '0;
    else        rcnt_q <= rcnt_d;
  end

  assign row_cnt = rcnt_q;
`endif

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .WIDTH(PORT_WIDTH),
      .DEPTH(lane_latency(i, STAGGER))
    ) u_a_line (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (row_acc),
      .data_i   (row_a[i*PORT_WIDTH +: PORT_WIDTH]),
      .data_o   (a_out[i*PORT_WIDTH +: PORT_WIDTH]),
      .valid_o  (a_vld[i]),
      .pending_o(a_pend[i])
    );

    skew_delay_line #(
      .WIDTH(PORT_WIDTH),
      .DEPTH(lane_latency(i, STAGGER))
    ) u_b_line (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .valid_i  (row_acc),
      .data_i   (row_b[i*PORT_WIDTH +: PORT_WIDTH]),
      .data_o   (b_out[i*PORT_WIDTH +: PORT_WIDTH]),
      .valid_o  (b_vld[i]),
      .pending_o(b_pend[i])
    );
  end

endmodule

// File: tb/tb_pe_array_feeder.sv
// Directed bench for pe_array_feeder (default parameters); connects row_cnt
// when FEEDER_ROW_CNT_EN is defined.
module tb_pe_array_feeder;

  localparam int W = 8;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst_n, wload_start, w_valid, w_ready, row_valid, row_ready;
  logic [W-1:0]   w_data, weight_in;
  logic [N*W-1:0] row_a, row_b, a_out, b_out;
  logic [4:0]     weight_location;
  logic           WorI, busy, wload_done;
`ifdef FEEDER_ROW_CNT_EN
  logic [15:0]    row_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int wori_cnt, done_cnt;

  always #5 clk = ~clk;

  pe_array_feeder #(
    .PORT_WIDTH(W),
    .N         (N),
    .STAGGER   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wload_start    (wload_start),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_data         (w_data),
    .row_valid      (row_valid),
    .row_ready      (row_ready),
    .row_a          (row_a),
    .row_b          (row_b),
    .WorI           (WorI),
    .weight_in      (weight_in),
    .weight_location(weight_location),
    .a_out          (a_out),
    .b_out          (b_out),
    .busy           (busy),
    .wload_done     (wload_done)
`ifdef FEEDER_ROW_CNT_EN
    ,
    .row_cnt        (row_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row k, lane i carries k*5+i on a and its negation on b.
  function automatic logic [N*W-1:0] row_vec(input int k, input bit neg);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      v[i*W +: W] = neg ? W'(-(k * 5 + i)) : W'(k * 5 + i);
    end
    return v;
  endfunction

  // Expected output after edge e when rows 0..last were accepted on edges 0..last.
  function automatic logic [N*W-1:0] exp_vec(input int e, input bit neg, input int last);
    logic [N*W-1:0] v;
    int r;
    v = '0;
    for (int i = 0; i < N; i++) begin
      r = e - 4 * i;
      if (r >= 0 && r <= last) v[i*W +: W] = neg ? W'(-(r * 5 + i)) : W'(r * 5 + i);
    end
    return v;
  endfunction

  task automatic enter_load();
    wload_start = 1'b1;
    tick();
    wload_start = 1'b0;
    chk("wori_entry", 64'(WorI), 64'd1);
    wori_cnt = 1;
    done_cnt = 0;
  endtask

  task automatic run_weights(input bit gaps);
    int k   = 0;
    int cyc = 0;
    bit v;
    while (k < 25 && cyc < 200) begin
      v       = !gaps || (cyc % 2 == 0);
      w_valid = v;
      w_data  = W'(k + 1);
      chk("w_ready_wload", 64'(w_ready), 64'd1);
      tick();
      cyc++;
      if (WorI) wori_cnt++;
      if (wload_done) done_cnt++;
      if (v) begin
        chk("weight_in", 64'(weight_in), 64'(k + 1));
        chk("weight_loc", 64'(weight_location), 64'(k));
        k++;
      end else begin
        chk("loc_hold", 64'(weight_location), 64'(k - 1));
      end
    end
    chk("load_complete", 64'(k), 64'd25);
    w_valid = 1'b1;
    w_data  = 8'hEE;
    chk("done_pulse", 64'(wload_done), 64'd1);
    chk("w_ready_wdone", 64'(w_ready), 64'd0);
    tick();
    if (WorI) wori_cnt++;
    if (wload_done) done_cnt++;
    chk("done_low", 64'(wload_done), 64'd0);
    chk("wori_hold", 64'(WorI), 64'd1);
    chk("extra_not_taken", 64'(weight_in), 64'd25);
    tick();
    if (WorI) wori_cnt++;
    chk("wori_fall", 64'(WorI), 64'd0);
    chk("extra_loc", 64'(weight_location), 64'd24);
    w_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    wload_start = 1'b0;
    w_valid     = 1'b1;
    row_valid   = 1'b1;
    w_data      = 8'h5A;
    row_a       = 40'h1122334455;
    row_b       = 40'h99AABBCCDD;
    repeat (5) tick();
    chk("rst_wori", 64'(WorI), 64'd0);
    chk("rst_weight_in", 64'(weight_in), 64'd0);
    chk("rst_loc", 64'(weight_location), 64'd0);
    chk("rst_a_out", 64'(a_out), 64'd0);
    chk("rst_b_out", 64'(b_out), 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_row_ready", 64'(row_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(wload_done), 64'd0);
    rst_n     = 1'b1;
    w_valid   = 1'b0;
    row_valid = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_row_ready", 64'(row_ready), 64'd1);

    // Gapless weight load.
    enter_load();
    run_weights(1'b0);
    chk("wori_cycles", 64'(wori_cnt), 64'd27);
    chk("done_count", 64'(done_cnt), 64'd1);

    // Weight load with alternate-cycle gaps.
    enter_load();
    run_weights(1'b1);
    chk("gap_done_count", 64'(done_cnt), 64'd1);

    // Reset in the middle of a load, then a clean reload from location 0.
    enter_load();
    for (int j = 0; j < 10; j++) begin
      w_valid = 1'b1;
      w_data  = W'(j + 1);
      tick();
    end
    chk("mid_loc_before_rst", 64'(weight_location), 64'd9);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_wori", 64'(WorI), 64'd0);
    chk("mid_rst_loc", 64'(weight_location), 64'd0);
    chk("mid_rst_w_ready", 64'(w_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst_n   = 1'b1;
    w_valid = 1'b0;
    tick();
    chk("mid_rst_idle", 64'(row_ready), 64'd1);
    enter_load();
    run_weights(1'b0);

    // Single row: a={5,4,3,2,1}, b={-1,-2,-3,-4,-5}.
    row_a     = 40'h0504030201;
    row_b     = 40'hFFFEFDFCFB;
    row_valid = 1'b1;
    chk("single_row_ready", 64'(row_ready), 64'd1);
    tick();
    row_valid = 1'b0;
    for (int d = 0; d <= 17; d++) begin
      logic [N*W-1:0] ea, eb;
      if (d > 0) tick();
      case (d)
        0:       begin ea = 40'h0000000001; eb = 40'h00000000FB; end
        4:       begin ea = 40'h0000000200; eb = 40'h000000FC00; end
        8:       begin ea = 40'h0000030000; eb = 40'h0000FD0000; end
        12:      begin ea = 40'h0004000000; eb = 40'h00FE000000; end
        16:      begin ea = 40'h0500000000; eb = 40'hFF00000000; end
        default: begin ea = '0;             eb = '0;             end
      endcase
      chk($sformatf("single_a_d%0d", d), 64'(a_out), 64'(ea));
      chk($sformatf("single_b_d%0d", d), 64'(b_out), 64'(eb));
    end
    chk("single_busy_end", 64'(busy), 64'd0);

    // 25 back-to-back rows, then wload_start while lanes are busy.
    for (int e = 0; e < 25; e++) begin
      row_a     = row_vec(e, 1'b0);
      row_b     = row_vec(e, 1'b1);
      row_valid = 1'b1;
      chk("b2b_row_ready", 64'(row_ready), 64'd1);
      tick();
      chk($sformatf("b2b_a_e%0d", e), 64'(a_out), 64'(exp_vec(e, 1'b0, 24)));
      chk($sformatf("b2b_b_e%0d", e), 64'(b_out), 64'(exp_vec(e, 1'b1, 24)));
    end
    row_a       = row_vec(25, 1'b0);
    row_b       = row_vec(25, 1'b1);
    wload_start = 1'b1;
    #1;
    chk("wload_blocks_row", 64'(row_ready), 64'd0);
    for (int e = 25; e <= 41; e++) begin
      tick();
      if (e == 25) begin
        wload_start = 1'b0;
        row_valid   = 1'b0;
      end
      chk($sformatf("drain_a_e%0d", e), 64'(a_out), 64'(exp_vec(e, 1'b0, 24)));
      chk($sformatf("drain_b_e%0d", e), 64'(b_out), 64'(exp_vec(e, 1'b1, 24)));
      chk($sformatf("drain_wori_e%0d", e), 64'(WorI), 64'(e == 41));
`ifdef FEEDER_ROW_CNT_EN
      if (e == 40) chk("row_cnt_before_load", 64'(row_cnt), 64'd26);
      if (e == 41) chk("row_cnt_cleared", 64'(row_cnt), 64'd0);
`endif
    end
    chk("drain_busy", 64'(busy), 64'd1);
    wori_cnt = 1;
    done_cnt = 0;
    run_weights(1'b0);
    chk("post_drain_done", 64'(done_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
